// File: rtl/btb_pkg.sv
// Shared types and helpers for the set-associative branch target buffer.
package btb_pkg;

  typedef enum logic [0:0] {IDLE, FLUSH} btb_state_e;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Two-bit saturating direction counter step
  function automatic logic [1:0] sat_ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    case (ctr)
      CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
      default: nxt = taken ? CTR_ST  : CTR_WT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/btb_victim_sel.sv
// Replacement way choice: lowest invalid way, else the round-robin way.
module btb_victim_sel
  import btb_pkg::*;
#(
  parameter int unsigned WAYS = 2,
  parameter int unsigned RR_W = 1
) (
  input  logic [WAYS-1:0] valid_i,
  input  logic [RR_W-1:0] rr_i,
  output logic [RR_W-1:0] victim_c,
  output logic            adv_rr_c
);

  always_comb begin
    victim_c = rr_i;
    adv_rr_c = (WAYS > 1);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) begin
        victim_c = RR_W'(w);
        adv_rr_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/btb_predictor_sa.sv
// N-way set-associative BTB with 2-bit direction counters, combinational
// lookup, registered training and a one-set-per-cycle flush walker.
module btb_predictor_sa
  import btb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned SETS        = 64,
  parameter int unsigned WAYS        = 2,
  parameter int unsigned OFFSET_BITS = 2,
  parameter logic [1:0]  CTR_INIT    = CTR_WT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] lookup_pc_i,
  output logic                  lookup_hit_o,
  output logic                  lookup_taken_o,
  output logic [ADDR_WIDTH-1:0] lookup_trgt_o,
  input  logic                  upd_valid_i,
  input  logic [ADDR_WIDTH-1:0] upd_pc_i,
  input  logic                  upd_taken_i,
  input  logic [ADDR_WIDTH-1:0] upd_trgt_i,
  input  logic                  flush_i,
  output logic                  busy_o
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = ADDR_WIDTH - OFFSET_BITS - IDX_W;
  localparam int unsigned RR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  btb_state_e       state_q, state_d;
  logic [IDX_W-1:0] fc_q, fc_d;

  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAYS-1:0]       valid_d [SETS];
  logic [RR_W-1:0]       rr_q    [SETS];
  logic [RR_W-1:0]       rr_d    [SETS];
  logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
  logic [TAG_W-1:0]      tag_d   [SETS][WAYS];
  logic [ADDR_WIDTH-1:0] trgt_q  [SETS][WAYS];
  logic [ADDR_WIDTH-1:0] trgt_d  [SETS][WAYS];
  logic [1:0]            ctr_q   [SETS][WAYS];
  logic [1:0]            ctr_d   [SETS][WAYS];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic [RR_W-1:0]  lk_way, upd_way, victim;
  logic             lk_found, upd_hit, adv_rr, upd_en;
  logic             unused_pc_bits;

  assign lk_idx  = lookup_pc_i[OFFSET_BITS +: IDX_W];
  assign lk_tag  = lookup_pc_i[OFFSET_BITS + IDX_W +: TAG_W];
  assign upd_idx = upd_pc_i[OFFSET_BITS +: IDX_W];
  assign upd_tag = upd_pc_i[OFFSET_BITS + IDX_W +: TAG_W];
  assign unused_pc_bits = ^{lookup_pc_i[OFFSET_BITS-1:0], upd_pc_i[OFFSET_BITS-1:0]};

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
    end
  end

  // FSM next state: flush walks every set once, a new request mid-walk is ignored
  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = FLUSH;
          fc_d    = '0;
        end
      end
      FLUSH: begin
        fc_d = fc_q + 1'b1;
        if (fc_q == IDX_W'(SETS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; a flush request in IDLE takes priority over a same-cycle update
  always_comb begin
    busy_o = (state_q == FLUSH);
    upd_en = upd_valid_i && (state_q == IDLE) && !flush_i;
  end

  // Lookup against pre-update contents; lowest matching way wins
  always_comb begin
    lk_found = 1'b0;
    lk_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
        lk_found = 1'b1;
        lk_way   = RR_W'(w);
      end
    end
    lookup_hit_o   = lk_found && (state_q == IDLE);
    lookup_taken_o = lookup_hit_o && ctr_q[lk_idx][lk_way][1];
    lookup_trgt_o  = lookup_hit_o ? trgt_q[lk_idx][lk_way] : '0;
  end

  btb_victim_sel #(
    .WAYS (WAYS),
    .RR_W (RR_W)
  ) u_victim_sel (
    .valid_i  (valid_q[upd_idx]),
    .rr_i     (rr_q[upd_idx]),
    .victim_c (victim),
    .adv_rr_c (adv_rr)
  );

  // Training and flush clearing of the table
  always_comb begin
    valid_d = valid_q;
    rr_d    = rr_q;
    tag_d   = tag_q;
    trgt_d  = trgt_q;
    ctr_d   = ctr_q;
    upd_hit = 1'b0;
    upd_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[upd_idx][w] && (tag_q[upd_idx][w] == upd_tag)) begin
        upd_hit = 1'b1;
        upd_way = RR_W'(w);
      end
    end
    if (upd_en) begin
      if (upd_hit) begin
        ctr_d[upd_idx][upd_way] = sat_ctr_next(ctr_q[upd_idx][upd_way], upd_taken_i);
        if (upd_taken_i) trgt_d[upd_idx][upd_way] = upd_trgt_i;
      end else if (upd_taken_i) begin
        valid_d[upd_idx][victim] = 1'b1;
        tag_d[upd_idx][victim]   = upd_tag;
        trgt_d[upd_idx][victim]  = upd_trgt_i;
        ctr_d[upd_idx][victim]   = CTR_INIT;
        if (adv_rr) rr_d[upd_idx] = rr_q[upd_idx] + 1'b1;
      end
    end
    if (state_q == FLUSH) begin
      valid_d[fc_q] = '0;
      rr_d[fc_q]    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      valid_q <= valid_d;
      rr_q    <= rr_d;
    end
  end

  // Payload arrays are qualified by valid and need no reset
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    trgt_q <= trgt_d;
    ctr_q  <= ctr_d;
  end

endmodule

// File: tb/tb_btb_predictor_sa.sv
// Self-checking bench for btb_predictor_sa: directed vector table, hand-written
// flush/reset sequences and randomized traffic against a behavioural model.
module tb_btb_predictor_sa;

  localparam int unsigned AW   = 32;
  localparam int unsigned NS   = 64;
  localparam int unsigned NW   = 2;
  localparam int unsigned OB   = 2;
  localparam int unsigned IDXB = 6;
  localparam int          NVEC = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] lookup_pc_i;
  logic          lookup_hit_o;
  logic          lookup_taken_o;
  logic [AW-1:0] lookup_trgt_o;
  logic          upd_valid_i;
  logic [AW-1:0] upd_pc_i;
  logic          upd_taken_i;
  logic [AW-1:0] upd_trgt_i;
  logic          flush_i;
  logic          busy_o;

  int total = 0;
  int bad   = 0;

  btb_predictor_sa #(
    .ADDR_WIDTH  (AW),
    .SETS        (NS),
    .WAYS        (NW),
    .OFFSET_BITS (OB),
    .CTR_INIT    (2'b10)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .lookup_pc_i    (lookup_pc_i),
    .lookup_hit_o   (lookup_hit_o),
    .lookup_taken_o (lookup_taken_o),
    .lookup_trgt_o  (lookup_trgt_o),
    .upd_valid_i    (upd_valid_i),
    .upd_pc_i       (upd_pc_i),
    .upd_taken_i    (upd_taken_i),
    .upd_trgt_i     (upd_trgt_i),
    .flush_i        (flush_i),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  // Behavioural model: table of entries per set plus a flush progress counter
  bit          m_v    [NS][NW];
  int unsigned m_tag  [NS][NW];
  int unsigned m_trgt [NS][NW];
  int          m_ctr  [NS][NW];
  int          m_rr   [NS];
  bit          m_busy;
  int          m_fc;

  function automatic void model_reset();
    for (int s = 0; s < NS; s++) begin
      for (int w = 0; w < NW; w++) m_v[s][w] = 1'b0;
      m_rr[s] = 0;
    end
    m_busy = 1'b0;
    m_fc   = 0;
  endfunction

  function automatic int model_find(int unsigned pc);
    int unsigned idx = (pc >> OB) % NS;
    int unsigned tag = pc >> (OB + IDXB);
    for (int w = 0; w < NW; w++)
      if (m_v[idx][w] && m_tag[idx][w] == tag) return w;
    return -1;
  endfunction

  function automatic void model_update(int unsigned pc, bit t, int unsigned tg);
    int unsigned idx = (pc >> OB) % NS;
    int unsigned tag = pc >> (OB + IDXB);
    int w = model_find(pc);
    int vic = -1;
    if (w >= 0) begin
      if (t) begin
        m_ctr[idx][w]  = (m_ctr[idx][w] == 3) ? 3 : m_ctr[idx][w] + 1;
        m_trgt[idx][w] = tg;
      end else begin
        m_ctr[idx][w] = (m_ctr[idx][w] == 0) ? 0 : m_ctr[idx][w] - 1;
      end
    end else if (t) begin
      for (int k = NW - 1; k >= 0; k--) if (!m_v[idx][k]) vic = k;
      if (vic < 0) begin
        vic = m_rr[idx];
        m_rr[idx] = (m_rr[idx] + 1) % NW;
      end
      m_v[idx][vic]    = 1'b1;
      m_tag[idx][vic]  = tag;
      m_trgt[idx][vic] = tg;
      m_ctr[idx][vic]  = 2;
    end
  endfunction

  function automatic void model_clock(bit f, bit uv, int unsigned pc, bit t, int unsigned tg);
    if (m_busy) begin
      for (int w = 0; w < NW; w++) m_v[m_fc][w] = 1'b0;
      m_rr[m_fc] = 0;
      m_fc++;
      if (m_fc == NS) m_busy = 1'b0;
    end else if (f) begin
      m_busy = 1'b1;
      m_fc   = 0;
    end else if (uv) begin
      model_update(pc, t, tg);
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    int  w  = model_find(lookup_pc_i);
    bit  eh = !m_busy && (w >= 0);
    bit  et = eh && (m_ctr[(lookup_pc_i >> OB) % NS][w] >= 2);
    logic [31:0] etg = eh ? m_trgt[(lookup_pc_i >> OB) % NS][w] : 32'h0;
    check({name, "_busy"},  32'(busy_o), 32'(m_busy));
    check({name, "_hit"},   32'(lookup_hit_o), 32'(eh));
    check({name, "_taken"}, 32'(lookup_taken_o), 32'(et));
    check({name, "_trgt"},  lookup_trgt_o, etg);
  endtask

  task automatic drive(input bit uv, input logic [31:0] upc, input bit ut,
                       input logic [31:0] utg, input logic [31:0] lpc, input bit f);
    upd_valid_i = uv;
    upd_pc_i    = upc;
    upd_taken_i = ut;
    upd_trgt_i  = utg;
    lookup_pc_i = lpc;
    flush_i     = f;
  endtask

  // One clock; the model consumes exactly the inputs the DUT sampled
  task automatic tick();
    bit          f  = flush_i;
    bit          uv = upd_valid_i;
    bit          t  = upd_taken_i;
    int unsigned pc = upd_pc_i;
    int unsigned tg = upd_trgt_i;
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else     model_clock(f, uv, pc, t, tg);
  endtask

  typedef struct {
    bit          uv;
    logic [31:0] upc;
    bit          ut;
    logic [31:0] utg;
    logic [31:0] lpc;
    bit          eh;
    bit          et;
    logic [31:0] etg;
  } vec_t;

  vec_t vecs [NVEC];

  initial begin
    int cnt;
    logic [31:0] gone [8];

    // update, then the following cycle's lookup and its expected result
    vecs[0]  = '{1'b0, 32'h000, 1'b0, 32'h0,    32'h100, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h100, 1'b1, 32'h200,  32'h100, 1'b1, 1'b1, 32'h200};
    vecs[2]  = '{1'b1, 32'h100, 1'b0, 32'h0,    32'h100, 1'b1, 1'b0, 32'h200};
    vecs[3]  = '{1'b1, 32'h100, 1'b0, 32'h0,    32'h100, 1'b1, 1'b0, 32'h200};
    vecs[4]  = '{1'b1, 32'h100, 1'b0, 32'h0,    32'h100, 1'b1, 1'b0, 32'h200};
    vecs[5]  = '{1'b1, 32'h100, 1'b1, 32'h204,  32'h100, 1'b1, 1'b0, 32'h204};
    vecs[6]  = '{1'b1, 32'h100, 1'b1, 32'h208,  32'h100, 1'b1, 1'b1, 32'h208};
    vecs[7]  = '{1'b1, 32'h100, 1'b1, 32'h20c,  32'h100, 1'b1, 1'b1, 32'h20c};
    vecs[8]  = '{1'b1, 32'h100, 1'b1, 32'h210,  32'h100, 1'b1, 1'b1, 32'h210};
    vecs[9]  = '{1'b1, 32'h100, 1'b0, 32'h0,    32'h100, 1'b1, 1'b1, 32'h210};
    vecs[10] = '{1'b1, 32'h004, 1'b1, 32'h1004, 32'h004, 1'b1, 1'b1, 32'h1004};
    vecs[11] = '{1'b1, 32'h104, 1'b1, 32'h1104, 32'h104, 1'b1, 1'b1, 32'h1104};
    vecs[12] = '{1'b1, 32'h204, 1'b1, 32'h1204, 32'h004, 1'b0, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 32'h000, 1'b0, 32'h0,    32'h104, 1'b1, 1'b1, 32'h1104};
    vecs[14] = '{1'b0, 32'h000, 1'b0, 32'h0,    32'h204, 1'b1, 1'b1, 32'h1204};
    vecs[15] = '{1'b1, 32'h304, 1'b1, 32'h1304, 32'h104, 1'b0, 1'b0, 32'h0};
    vecs[16] = '{1'b0, 32'h000, 1'b0, 32'h0,    32'h204, 1'b1, 1'b1, 32'h1204};
    vecs[17] = '{1'b0, 32'h000, 1'b0, 32'h0,    32'h304, 1'b1, 1'b1, 32'h1304};
    vecs[18] = '{1'b1, 32'h300, 1'b0, 32'h999,  32'h300, 1'b0, 1'b0, 32'h0};
    vecs[19] = '{1'b0, 32'h000, 1'b0, 32'h0,    32'h100, 1'b1, 1'b1, 32'h210};

    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h100, 1'b0);
    model_reset();
    #1;
    check("in_reset_hit",  32'(lookup_hit_o), 32'h0);
    check("in_reset_trgt", lookup_trgt_o, 32'h0);
    check("in_reset_busy", 32'(busy_o), 32'h0);
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utg, vecs[i].lpc, 1'b0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 32'h0, vecs[i].lpc, 1'b0);
      #1;
      check($sformatf("vec%0d_hit", i),   32'(lookup_hit_o), 32'(vecs[i].eh));
      check($sformatf("vec%0d_taken", i), 32'(lookup_taken_o), 32'(vecs[i].et));
      check($sformatf("vec%0d_trgt", i),  lookup_trgt_o, vecs[i].etg);
    end

    // same-cycle update and lookup see the old contents
    drive(1'b1, 32'h508, 1'b1, 32'h77, 32'h508, 1'b0);
    #1;
    check("nobypass_hit", 32'(lookup_hit_o), 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h508, 1'b0);
    #1;
    check("after_upd_hit",  32'(lookup_hit_o), 32'h1);
    check("after_upd_trgt", lookup_trgt_o, 32'h77);

    // flush with a colliding update, a re-request and a mid-walk update
    drive(1'b1, 32'h60c, 1'b1, 32'h5, 32'h100, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h100, 1'b0);
    #1;
    check("flush_busy_start", 32'(busy_o), 32'h1);
    check("flush_hit_forced", 32'(lookup_hit_o), 32'h0);
    cnt = 0;
    while (busy_o === 1'b1 && cnt < 200) begin
      cnt++;
      if (cnt == 5)       drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h100, 1'b1);
      else if (cnt == 20) drive(1'b1, 32'h610, 1'b1, 32'h5, 32'h100, 1'b0);
      else                drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h100, 1'b0);
      tick();
    end
    check("flush_cycles", 32'(cnt), 32'(NS));
    gone[0] = 32'h100; gone[1] = 32'h204; gone[2] = 32'h304; gone[3] = 32'h508;
    gone[4] = 32'h60c; gone[5] = 32'h610; gone[6] = 32'h000; gone[7] = 32'h104;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'h0, 1'b0, 32'h0, gone[i], 1'b0);
      #1;
      check($sformatf("post_flush_miss%0d", i), 32'(lookup_hit_o), 32'h0);
    end

    // reset in the middle of a walk
    drive(1'b1, 32'h0a0, 1'b1, 32'ha0, 32'h0a0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0a0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0a0, 1'b0);
    repeat (10) tick();
    check("pre_rst_busy", 32'(busy_o), 32'h1);
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_busy_now", 32'(busy_o), 32'h0);
    check("rst_hit_now",  32'(lookup_hit_o), 32'h0);
    tick();
    rst = 1'b0;
    drive(1'b1, 32'h100, 1'b1, 32'h200, 32'h100, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h100, 1'b0);
    #1;
    check("post_rst_hit",   32'(lookup_hit_o), 32'h1);
    check("post_rst_taken", 32'(lookup_taken_o), 32'h1);
    check("post_rst_trgt",  lookup_trgt_o, 32'h200);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0a0, 1'b0);
    #1;
    check("post_rst_set40_miss", 32'(lookup_hit_o), 32'h0);

    // random traffic on a small PC pool so sets collide and evict
    for (int c = 0; c < 1500; c++) begin
      logic [31:0] upc, lpc;
      upc = ($urandom % 4) << 8 | ($urandom % 4) << 2 | ($urandom % 4);
      lpc = ($urandom % 4) << 8 | ($urandom % 4) << 2 | ($urandom % 4);
      drive(($urandom % 10) < 7, upc, 1'($urandom % 2), $urandom, lpc, ($urandom % 400) == 0);
      #1;
      check_model($sformatf("rnd%0d", c));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btb_predictor_sa.md
Name: btb_predictor_sa

Overview:
- Parametrised N-way set-associative branch target buffer with a per-entry 2-bit saturating direction counter.
- Sits in the IF stage, replacing the separate direct-mapped predictor and target buffer.
- Fetch PC is looked up combinationally. The resolved branch outcome from EX trains the table one cycle later.
- A multi-cycle flush walker clears the table on request.

Parameters:
- ADDR_WIDTH, 32, PC width in bits.
- SETS, 64, number of sets; must be a power of two, at least 2.
- WAYS, 2, associativity; must be a power of two, at least 1.
- OFFSET_BITS, 2, low PC bits ignored for indexing (4-byte instruction alignment).
- CTR_INIT, 2'b10, counter value written when an entry is allocated (weakly taken).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- lookup_pc_i  in  ADDR_WIDTH  fetch PC.
- lookup_hit_o  out  1  PC matches a valid entry.
- lookup_taken_o  out  1  predicted taken (hit and counter MSB = 1).
- lookup_trgt_o  out  ADDR_WIDTH  predicted target; 0 when there is no hit.
- upd_valid_i  in  1  resolved branch present this cycle.
- upd_pc_i  in  ADDR_WIDTH  PC of the resolved branch.
- upd_taken_i  in  1  actual direction.
- upd_trgt_i  in  ADDR_WIDTH  actual target.
- flush_i  in  1  one-cycle pulse that starts a table invalidation.
- busy_o  out  1  flush in progress.

Behaviour:
- Address split:
  - index = pc[OFFSET_BITS+IDX_W-1 : OFFSET_BITS], where IDX_W = clog2(SETS).
  - tag = pc[ADDR_WIDTH-1 : OFFSET_BITS+IDX_W].
- Storage per way per set: valid, tag, target, ctr[1:0]. Per set: round-robin pointer rr[clog2(WAYS)-1:0]. With WAYS=1 the pointer is constant 0.
- Reset (async):
  - All valid bits, rr pointers and the FSM go to IDLE; busy_o = 0.
  - Tag, target and counter arrays need not be reset.
  - Outputs while in reset: hit 0, taken 0, trgt 0.
- Lookup:
  - Purely combinational, zero latency.
  - Hit when a way in the set has valid=1 and a matching tag.
  - Multiple hits are illegal; if they occur, the lowest way wins.
  - While busy_o=1, lookup_hit_o and lookup_taken_o are forced to 0.
- Update (registered on the rising edge, visible to lookup from the next cycle). Applied only when upd_valid_i=1 and the FSM is IDLE.
  - Hit:
    - ctr saturating-increments if taken, saturating-decrements if not taken (11 holds at 11, 00 holds at 00).
    - target <= upd_trgt_i if taken; rr is unchanged.
  - Miss and taken:
    - Victim = lowest invalid way; if all ways are valid, victim = rr[set] and rr[set] increments modulo WAYS.
    - Write valid=1, tag, target, ctr=CTR_INIT.
    - rr does not advance when an invalid way is filled.
  - Miss and not taken: no state change.
- Same-cycle lookup and update to the same set: lookup returns the pre-update contents (no bypass).
- Flush FSM: states IDLE, FLUSH.
  - IDLE --flush_i--> FLUSH with set counter fc=0; busy_o=1 from the next cycle.
  - FLUSH: each cycle clears valid of every way in set fc, clears rr[fc], then fc++. After fc=SETS-1 is cleared, go to IDLE.
  - Flush takes exactly SETS cycles with busy_o high.
  - An update arriving during FLUSH, or in the same cycle flush_i is asserted in IDLE, is dropped; flush has priority.
  - flush_i during FLUSH is ignored; the walk does not restart.
  - Reset during FLUSH returns to IDLE immediately with all valids cleared.
- All pointer and counter arithmetic wraps at its declared width; there are no overflow outputs.

Decomposition:
- Package btb_pkg:
  - typedef enum {IDLE, FLUSH} btb_state_e.
  - Counter constants: CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11.
  - Function sat_ctr_next(ctr, taken).
- Sub-module btb_victim_sel (combinational): takes a valid vector and rr, and returns the victim way plus an "advance rr" flag.

Test Plan:
- Reset, then lookup at PC 0x100 -> hit 0, taken 0, trgt 0.
- Update PC 0x100, taken, trgt 0x200; next cycle lookup 0x100 -> hit 1, taken 1 (ctr 10), trgt 0x200. Two not-taken updates -> ctr 00, taken 0, hit 1. Third not-taken update -> ctr stays 00.
- WAYS=2, SETS=64: allocate PCs 0x000, 0x100, 0x200 (all map to set 0), all taken -> 0x000 evicted (rr=0 chosen, then rr=1); lookup 0x000 misses, 0x100 and 0x200 hit.
- Not-taken update at unseen PC 0x300 -> lookup 0x300 still misses; no other entry changes.
- Fill several sets, pulse flush_i -> busy_o high for exactly 64 cycles, an update issued mid-flush is dropped, all lookups miss afterwards.
- Assert rst at flush cycle 10 -> busy_o=0 immediately; the next update/lookup pair behaves as after a fresh reset.
